// File: rtl/mul_sequencer_if.sv
// Bus bundle for the multiply sequencer: issue request, multiplier core link and writeback result.
// The slave modport is the sequencer's view; the master modport is the surrounding pipeline and core.
interface mul_sequencer_if;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = 64;

  // Issue stage request
  logic          in_valid;
  logic          in_ready;
  logic          in_signed;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;

  // Iterative multiplier core
  logic          core_reset;
  logic [DW-1:0] core_a;
  logic [DW-1:0] core_b;
  logic [PW-1:0] core_product;
  logic          core_ready;

  // Writeback result
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_hi;
  logic [DW-1:0] out_lo;
  logic          out_err;

  modport slave (
    input  in_valid, in_signed, in_a, in_b,
    input  core_product, core_ready,
    input  out_ready,
    output in_ready,
    output core_reset, core_a, core_b,
    output out_valid, out_hi, out_lo, out_err
  );

  modport master (
    output in_valid, in_signed, in_a, in_b,
    output core_product, core_ready,
    output out_ready,
    input  in_ready,
    input  core_reset, core_a, core_b,
    input  out_valid, out_hi, out_lo, out_err
  );
endinterface

// File: rtl/mul_sequencer.sv
// Issue/writeback controller for the iterative 32x32 multiplier core: feeds operand
// magnitudes to the core, sign-corrects its product and hands {hi,lo} to writeback.
module mul_sequencer #(
  parameter int unsigned TIMEOUT     = 64,
  parameter bit          ZERO_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  mul_sequencer_if.slave  bus
);

  localparam int unsigned DW = 32;
  localparam int unsigned PW = 64;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic [PW-1:0] prod_q, prod_d;
  logic [DW-1:0] core_a_q, core_a_d;
  logic [DW-1:0] core_b_q, core_b_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic          err_q, err_d;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          core_reset_q;

  logic          accept_c;
  logic          zero_op_c;
  logic [PW-1:0] fixed_c;

  // Two's-complement magnitude; 0x80000000 maps to itself, which the unsigned core accepts.
  function automatic logic [DW-1:0] mag(input logic [DW-1:0] v, input logic s);
    mag = (s && v[DW-1]) ? DW'(~v + 1'b1) : v;
  endfunction

  assign accept_c  = in_ready_q & bus.in_valid;
  assign zero_op_c = (bus.in_a == '0) || (bus.in_b == '0);
  assign fixed_c   = neg_q ? PW'(~prod_q + 64'd1) : prod_q;

  // Next-state and datapath decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    prod_d   = prod_q;
    core_a_d = core_a_q;
    core_b_d = core_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          neg_d    = bus.in_signed & (bus.in_a[DW-1] ^ bus.in_b[DW-1]);
          core_a_d = mag(bus.in_a, bus.in_signed);
          core_b_d = mag(bus.in_b, bus.in_signed);
          cnt_d    = '0;
          if (ZERO_BYPASS && zero_op_c) begin
            hi_d    = '0;
            lo_d    = '0;
            err_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_CLEAR;
          end
        end
      end

      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end

      S_RUN: begin
        cnt_d = CW'(cnt_q + 1'b1);
        if (bus.core_ready) begin
          prod_d  = bus.core_product;
          state_d = S_FIX;
        end else if (cnt_d == CW'(TIMEOUT)) begin
          // Core never answered: abort with a zero result flagged as error.
          prod_d  = '0;
          hi_d    = '0;
          lo_d    = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_FIX: begin
        hi_d    = fixed_c[PW-1:DW];
        lo_d    = fixed_c[DW-1:0];
        err_d   = 1'b0;
        state_d = S_DONE;
      end

      S_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          hi_d    = '0;
          lo_d    = '0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; handshake flags follow the next state so they are Moore.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      neg_q        <= 1'b0;
      prod_q       <= '0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      err_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      neg_q        <= neg_d;
      prod_q       <= prod_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      err_q        <= err_d;
      in_ready_q   <= (state_d == S_IDLE);
      out_valid_q  <= (state_d == S_DONE);
      core_reset_q <= (state_d != S_RUN);
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.core_reset = core_reset_q;
  assign bus.core_a     = core_a_q;
  assign bus.core_b     = core_b_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_hi     = hi_q;
  assign bus.out_lo     = lo_q;
  assign bus.out_err    = err_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a cycle-counting core model and a result scoreboard.
module tb_mul_sequencer;

  localparam int TO     = 64;
  localparam int CORE_N = 32;

  typedef struct packed {
    logic [63:0] p;
    logic        e;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  mul_sequencer_if bus ();

  mul_sequencer #(.TIMEOUT(TO), .ZERO_BYPASS(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   total    = 0;
  int   bad      = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   core_cnt = 0;
  bit   core_en  = 1'b1;
  exp_t exp_q[$];

  // Core model: counts cycles out of clear and answers on its 32nd running cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.core_reset) core_cnt <= 0;
    else                core_cnt <= core_cnt + 1;
  end
  assign bus.core_ready   = core_en && !bus.core_reset && (core_cnt >= CORE_N - 1);
  assign bus.core_product = {32'd0, bus.core_a} * {32'd0, bus.core_b};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ext(input bit s, input logic [31:0] v);
    ext = s ? {{32{v[31]}}, v} : {32'd0, v};
  endfunction

  function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic signed [63:0] ea, eb;
    ea = ext(s, a);
    eb = ext(s, b);
    if (!core_en && a != 0 && b != 0) begin
      r.p = '0;
      r.e = 1'b1;
    end else begin
      r.p = ea * eb;
      r.e = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_mag(input bit s, input logic [31:0] v);
    logic signed [63:0] x;
    x = ext(s, v);
    if (x < 0) x = -x;
    return x[31:0];
  endfunction

  // Scoreboard compare on the falling edge whenever a result is presented.
  always @(negedge clk) begin
    if (reset && bus.out_valid) begin
      chk("in_ready_low_in_done", 64'(bus.in_ready), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'(bus.out_valid), 64'd0);
      end else begin
        chk("out_hilo", {bus.out_hi, bus.out_lo}, exp_q[0].p);
        chk("out_err", 64'(bus.out_err), 64'(exp_q[0].e));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    chk("rst_out_hilo", {bus.out_hi, bus.out_lo}, 64'd0);
    chk("rst_core_reset", 64'(bus.core_reset), 64'd1);
    chk("rst_core_ab", {bus.core_a, bus.core_b}, 64'd0);
  endtask

  task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      step();
      n++;
    end
    chk("issue_wait_in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_signed = s;
    bus.in_a      = a;
    bus.in_b      = b;
    @(posedge clk);
    exp_q.push_back(model(s, a, b));
    #1;
    acc_cyc       = cyc;
    bus.in_valid  = 1'b0;
    bus.in_signed = ~s;
    bus.in_a      = 32'hDEAD_BEEF;
    bus.in_b      = 32'h0BAD_F00D;
    chk("in_ready_after_issue", 64'(bus.in_ready), 64'd0);
    chk("core_a_mag", 64'(bus.core_a), 64'(ref_mag(s, a)));
    chk("core_b_mag", 64'(bus.core_b), 64'(ref_mag(s, b)));
  endtask

  task automatic take(input int hold, output logic [63:0] res, output bit err, output int lat);
    int n = 0;
    while (!bus.out_valid && n < 300) begin
      step();
      n++;
    end
    chk("result_wait", 64'(bus.out_valid), 64'd1);
    lat = cyc - acc_cyc + 1;
    res = {bus.out_hi, bus.out_lo};
    err = bus.out_err;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_data", {bus.out_hi, bus.out_lo}, res);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("in_ready_after_wb", 64'(bus.in_ready), 64'd1);
    chk("out_valid_drop", 64'(bus.out_valid), 64'd0);
    chk("err_cleared", 64'(bus.out_err), 64'd0);
  endtask

  task automatic run(input bit s, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] want, input bit want_err, input int want_lat,
                     input int hold);
    logic [63:0] res;
    bit          err;
    int          lat;
    issue(s, a, b);
    take(hold, res, err, lat);
    chk("lit_product", res, want);
    chk("lit_err", 64'(err), 64'(want_err));
    chk("latency", 64'(lat), 64'(want_lat));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    reset = 1'b0;
    repeat (3) step();
    reset_check();
    reset = 1'b1;
    step();

    // Core path: latency 1 clear + 32 run + 1 fix + 1
    run(1'b0, 32'd3,         32'd5,         64'h0000_0000_0000_000F, 1'b0, 35, 0);
    run(1'b1, 32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 35, 0);
    run(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 35, 0);
    run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 35, 0);
    run(1'b1, 32'hFFFF_FFFF, 32'd1,         64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 35, 0);
    run(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 35, 0);
    run(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 1'b0, 35, 0);
    run(1'b0, 32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000, 1'b0, 35, 0);

    // Zero bypass
    run(1'b1, 32'd0,         32'hFFFF_FFFF, 64'd0, 1'b0, 1, 0);
    run(1'b0, 32'h1234_5678, 32'd0,         64'd0, 1'b0, 1, 0);

    // Writeback back-pressure for 10 cycles
    run(1'b0, 32'd6, 32'd7, 64'h2A, 1'b0, 35, 10);

    // Reset during the 10th RUN cycle drops the request
    issue(1'b0, 32'd9, 32'd9);
    repeat (10) step();
    reset = 1'b0;
    step();
    exp_q.delete();
    reset_check();
    reset = 1'b1;
    repeat (45) step();
    chk("no_result_after_reset", 64'(bus.out_valid), 64'd0);
    run(1'b0, 32'd7, 32'd6, 64'h2A, 1'b0, 35, 0);

    // Dead core: timeout after 64 RUN cycles; bypass still works
    core_en = 1'b0;
    run(1'b1, 32'd5, 32'd7, 64'd0, 1'b1, TO + 2, 0);
    run(1'b0, 32'd0, 32'd9, 64'd0, 1'b0, 1, 0);
    core_en = 1'b1;
    run(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 64'h2A, 1'b0, 35, 2);

    repeat (3) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
